mem_sync_sp_lsu_port: RTL and testbench

Load/store front-end that sits directly upstream of the synchronous single-port data memory (write-first, 1-cycle read latency, per-byte write enables).
- Accepts byte-addressed valid/ready requests from the core LSU.
- Generates the word address, lane-shifted write data and byte enables.
- Returns exactly one formatted response per accepted request: a sign/zero-extended load value, or an ack for a store.
- Flags misaligned accesses without touching memory.

---
 rtl/mem_sync_sp_lsu_port.sv | 134 +++++++++++++
 tb/tb_mem_sync_sp_lsu_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sync_sp_lsu_port.sv
`default_nettype none
// ============================================================================
// Module      : mem_sync_sp_lsu_port
// Description : Load/store front-end for a synchronous single-port memory
//               with byte enables and a one-entry response slot.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sync_sp_lsu_port #(
    parameter int DEPTH       = 2048,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int DATA_WIDTH  = 64,
    parameter int DATA_BYTES  = DATA_WIDTH / 8,
    parameter int BADDR_WIDTH = ADDR_WIDTH + 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_we,
    input  logic [BADDR_WIDTH-1:0] i_req_addr,
    input  logic [1:0]             i_req_size,
    input  logic                   i_req_unsigned,
    input  logic [DATA_WIDTH-1:0]  i_req_wdata,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [DATA_WIDTH-1:0]  o_rsp_rdata,
    output logic                   o_rsp_err,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic [DATA_WIDTH-1:0]  o_mem_wdata,
    output logic [DATA_BYTES-1:0]  o_mem_wen,
    input  logic [DATA_WIDTH-1:0]  i_mem_rdata
);

    localparam logic [1:0] c_SIZE_BYTE = 2'd0;
    localparam logic [1:0] c_SIZE_HALF = 2'd1;
    localparam logic [1:0] c_SIZE_WORD = 2'd2;

    logic                  w_accept;
    logic                  w_store_en;
    logic                  w_misaligned;
    logic [2:0]            w_off;
    logic [2:0]            w_align_mask;
    logic [DATA_BYTES-1:0] w_size_wen;
    logic [DATA_WIDTH-1:0] w_lane;
    logic [DATA_WIDTH-1:0] w_load;
    logic                  w_sign;

    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic                  r_rsp_valid;
    logic [2:0]            r_off;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic                  r_we;
    logic                  r_err;

    // Request decode: alignment mask and unshifted byte-enable pattern per size
    always_comb begin
        w_off        = i_req_addr[2:0];
        w_align_mask = 3'b111;
        w_size_wen   = 8'hFF;
        case (i_req_size)
            c_SIZE_BYTE: begin w_align_mask = 3'b000; w_size_wen = 8'h01; end
            c_SIZE_HALF: begin w_align_mask = 3'b001; w_size_wen = 8'h03; end
            c_SIZE_WORD: begin w_align_mask = 3'b011; w_size_wen = 8'h0F; end
            default:     begin w_align_mask = 3'b111; w_size_wen = 8'hFF; end
        endcase
        w_misaligned = |(w_off & w_align_mask);
    end

    // Reset blocks acceptance so no write enable can leak out while rst is high
    assign o_req_ready = !rst && (!r_rsp_valid || i_rsp_ready);
    assign w_accept    = i_req_valid && o_req_ready;
    assign w_store_en  = w_accept && i_req_we && !w_misaligned;

    assign o_mem_addr  = w_accept   ? i_req_addr[BADDR_WIDTH-1:3] : r_last_addr;
    assign o_mem_wen   = w_store_en ? (w_size_wen << w_off) : '0;
    assign o_mem_wdata = w_store_en ? (i_req_wdata << {w_off, 3'b000}) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_addr <= '0;
            r_rsp_valid <= 1'b0;
            r_off       <= 3'd0;
            r_size      <= 2'd0;
            r_unsigned  <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_addr <= i_req_addr[BADDR_WIDTH-1:3];
                r_rsp_valid <= 1'b1;
                r_off       <= w_off;
                r_size      <= i_req_size;
                r_unsigned  <= i_req_unsigned;
                r_we        <= i_req_we;
                r_err       <= w_misaligned;
            end else if (i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Load formatting works straight off the memory output, which stays stable
    // during a stall because the word address is held.
    always_comb begin
        w_lane = i_mem_rdata >> {r_off, 3'b000};
        w_sign = 1'b0;
        w_load = w_lane;
        case (r_size)
            c_SIZE_BYTE: begin
                w_sign = !r_unsigned && w_lane[7];
                w_load = {{56{w_sign}}, w_lane[7:0]};
            end
            c_SIZE_HALF: begin
                w_sign = !r_unsigned && w_lane[15];
                w_load = {{48{w_sign}}, w_lane[15:0]};
            end
            c_SIZE_WORD: begin
                w_sign = !r_unsigned && w_lane[31];
                w_load = {{32{w_sign}}, w_lane[31:0]};
            end
            default: begin
                w_sign = 1'b0;
                w_load = w_lane;
            end
        endcase
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_valid && r_err;
    assign o_rsp_rdata = (r_rsp_valid && !r_we && !r_err) ? w_load : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_sync_sp_lsu_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_sync_sp_lsu_port
// Description : Directed scoreboard bench with a write-first memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_sync_sp_lsu_port;

    localparam int AW  = 11;
    localparam int BAW = 14;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_req_valid = 1'b0;
    logic            o_req_ready;
    logic            i_req_we = 1'b0;
    logic [BAW-1:0]  i_req_addr = '0;
    logic [1:0]      i_req_size = 2'd0;
    logic            i_req_unsigned = 1'b0;
    logic [63:0]     i_req_wdata = '0;
    logic            o_rsp_valid;
    logic            i_rsp_ready = 1'b1;
    logic [63:0]     o_rsp_rdata;
    logic            o_rsp_err;
    logic [AW-1:0]   o_mem_addr;
    logic [63:0]     o_mem_wdata;
    logic [7:0]      o_mem_wen;
    logic [63:0]     i_mem_rdata;

    mem_sync_sp_lsu_port dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_addr     (i_req_addr),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .o_mem_wen      (o_mem_wen),
        .i_mem_rdata    (i_mem_rdata)
    );

    always #5 clk = ~clk;

    // Write-first synchronous single-port memory
    logic [63:0] mem [0:2047];
    always @(posedge clk) begin : p_mem
        logic [63:0] t;
        t = mem[o_mem_addr];
        for (int b = 0; b < 8; b++)
            if (o_mem_wen[b]) t[b*8 +: 8] = o_mem_wdata[b*8 +: 8];
        mem[o_mem_addr] <= t;
        i_mem_rdata     <= t;
    end

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   rsp_count = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : p_mon
        rsp_t e;
        if (!rst && o_rsp_valid && i_rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'(o_rsp_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", o_rsp_rdata, e.rdata);
                chk("rsp_err", 64'(o_rsp_err), 64'(e.err));
                rsp_count++;
            end
        end
    end

    task automatic issue(input string tag, input logic we, input logic [BAW-1:0] addr,
                         input logic [1:0] size, input logic uns, input logic [63:0] wd,
                         input logic [7:0] exp_wen, input logic [63:0] exp_wdata,
                         input logic [63:0] exp_rdata, input logic exp_err);
        rsp_t r;
        i_req_valid    = 1'b1;
        i_req_we       = we;
        i_req_addr     = addr;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_wdata    = wd;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(o_req_ready), 64'd1);
        chk({tag, "_wen"}, 64'(o_mem_wen), 64'(exp_wen));
        chk({tag, "_addr"}, 64'(o_mem_addr), 64'(addr[BAW-1:3]));
        if (exp_wen != 8'h00) chk({tag, "_wdata"}, o_mem_wdata, exp_wdata);
        r.rdata = exp_rdata;
        r.err   = exp_err;
        sb.push_back(r);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        i_req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin : p_stim
        logic [7:0] bexp [8];
        int c0;
        bexp = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'hF0, 8'h11};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("rst_wen", 64'(o_mem_wen), 64'd0);
        chk("rst_addr", 64'(o_mem_addr), 64'd0);
        chk("rst_wdata", o_mem_wdata, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(o_req_ready), 64'd1);
        @(posedge clk); #1;

        issue("st_z50", 1'b1, 14'h50, 2'd3, 1'b0, 64'h0, 8'hFF, 64'h0, 64'h0, 1'b0);
        issue("st_z58", 1'b1, 14'h58, 2'd3, 1'b0, 64'h0, 8'hFF, 64'h0, 64'h0, 1'b0);
        issue("st_d40", 1'b1, 14'h40, 2'd3, 1'b0, 64'h1122334455667788, 8'hFF,
              64'h1122334455667788, 64'h0, 1'b0);
        issue("ld_d40", 1'b0, 14'h40, 2'd3, 1'b0, 64'h0, 8'h00, 64'h0, 64'h1122334455667788, 1'b0);
        issue("ld_b45s", 1'b0, 14'h45, 2'd0, 1'b0, 64'h0, 8'h00, 64'h0, 64'h33, 1'b0);
        issue("ld_b45u", 1'b0, 14'h45, 2'd0, 1'b1, 64'h0, 8'h00, 64'h0, 64'h33, 1'b0);
        issue("st_b46", 1'b1, 14'h46, 2'd0, 1'b0, 64'hF0, 8'h40, 64'h00F0_0000_0000_0000, 64'h0, 1'b0);
        issue("ld_b46s", 1'b0, 14'h46, 2'd0, 1'b0, 64'h0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        issue("ld_b46u", 1'b0, 14'h46, 2'd0, 1'b1, 64'h0, 8'h00, 64'h0, 64'hF0, 1'b0);
        issue("st_h43", 1'b1, 14'h43, 2'd1, 1'b0, 64'hBEEF, 8'h00, 64'h0, 64'h0, 1'b1);
        issue("ld_w42", 1'b0, 14'h42, 2'd2, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1);
        issue("ld_d44", 1'b0, 14'h44, 2'd3, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1);
        issue("ld_d40b", 1'b0, 14'h40, 2'd3, 1'b0, 64'h0, 8'h00, 64'h0, 64'h11F0334455667788, 1'b0);
        issue("ld_h44s", 1'b0, 14'h44, 2'd1, 1'b0, 64'h0, 8'h00, 64'h0, 64'h3344, 1'b0);
        issue("ld_w44s", 1'b0, 14'h44, 2'd2, 1'b0, 64'h0, 8'h00, 64'h0, 64'h11F03344, 1'b0);

        // Stall: response held while a store waits at the request port
        issue("st_w48", 1'b1, 14'h48, 2'd2, 1'b0, 64'h80000000, 8'h0F, 64'h80000000, 64'h0, 1'b0);
        idle();
        i_rsp_ready = 1'b0;
        issue("ld_w48", 1'b0, 14'h48, 2'd2, 1'b0, 64'h0, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000, 1'b0);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_addr  = 14'h50;
        i_req_size  = 2'd2;
        i_req_wdata = 64'h12345678;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_ready", 64'(o_req_ready), 64'd0);
            chk("stall_valid", 64'(o_rsp_valid), 64'd1);
            chk("stall_rdata", o_rsp_rdata, 64'hFFFF_FFFF_8000_0000);
            chk("stall_addr", 64'(o_mem_addr), 64'h9);
            chk("stall_wen", 64'(o_mem_wen), 64'd0);
            @(posedge clk); #1;
        end
        i_rsp_ready = 1'b1;
        issue("st_w50", 1'b1, 14'h50, 2'd2, 1'b0, 64'h12345678, 8'h0F, 64'h12345678, 64'h0, 1'b0);
        idle();

        c0 = rsp_count;
        for (int i = 0; i < 8; i++)
            issue("ld_stream", 1'b0, 14'(14'h40 + i), 2'd0, 1'b1, 64'h0, 8'h00, 64'h0,
                  64'(bexp[i]), 1'b0);
        idle();
        chk("stream_count", 64'(rsp_count - c0), 64'd8);

        issue("st_cafe", 1'b1, 14'h50, 2'd2, 1'b0, 64'hCAFEBABE, 8'h0F, 64'hCAFEBABE, 64'h0, 1'b0);
        issue("ld_w54", 1'b0, 14'h54, 2'd2, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b0);
        issue("ld_d50", 1'b0, 14'h50, 2'd3, 1'b0, 64'h0, 8'h00, 64'h0, 64'h00000000CAFEBABE, 1'b0);
        idle();

        // Reset while a response is pending and a store is presented
        i_rsp_ready = 1'b0;
        issue("ld_d40c", 1'b0, 14'h40, 2'd3, 1'b0, 64'h0, 8'h00, 64'h0, 64'h11F0334455667788, 1'b0);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_addr  = 14'h58;
        i_req_size  = 2'd3;
        i_req_wdata = 64'hDEADBEEF_DEADBEEF;
        i_rsp_ready = 1'b1;
        rst         = 1'b1;
        #1;
        chk("arst_valid", 64'(o_rsp_valid), 64'd0);
        chk("arst_wen", 64'(o_mem_wen), 64'd0);
        sb.delete();
        @(negedge clk);
        chk("arst_wen_hold", 64'(o_mem_wen), 64'd0);
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        rst         = 1'b0;
        @(posedge clk); #1;
        issue("ld_d58", 1'b0, 14'h58, 2'd3, 1'b0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b0);
        issue("ld_d40d", 1'b0, 14'h40, 2'd3, 1'b0, 64'h0, 8'h00, 64'h0, 64'h11F0334455667788, 1'b0);
        idle();
        idle();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
